eq_stream_checker: RTL and testbench
====================================

Name: eq_stream_checker

Overview:
- Parametrised equivalence-check harness for two designs under comparison, side A (ILA model) and side B (HLS RTL).
- Both designs drive one output stream each. The block buffers each stream independently, compares beats in order, and gates each side's execution with a run enable instead of a gated clock.
- Tracks per-side completion, counts cycles and beats, and reports pass, fail or timeout together with the first mismatching pair.
- Sits at the top of the equivalence wrapper, between the two design instances and the property/bench layer.

Parameters:
DATA_W, 8, stream data width in bits
DEPTH, 4, per-side buffer depth in entries (power of two, ≥2)
CNT_W, 16, width of the cycle and beat counters
MAX_CYCLES, 1000, RUN-cycle bound before timeout (< 2^CNT_W)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that begins a check
a_tdata  in  DATA_W  side A output data
a_tvalid  in  1  side A data valid
a_tready  out  1  accept from side A
b_tdata  in  DATA_W  side B output data
b_tvalid  in  1  side B data valid
b_tready  out  1  accept from side B
a_complete  in  1  side A instruction finished
b_complete  in  1  side B instruction finished
a_run  out  1  side A execution enable
b_run  out  1  side B execution enable
busy  out  1  state is RUN or DRAIN
done  out  1  state is PASS or FAIL
pass  out  1  check passed (valid while done)
mismatch  out  1  data or beat-count mismatch detected
timeout  out  1  MAX_CYCLES reached
beat_cnt  out  CNT_W  compared beats, saturating
cycle_cnt  out  CNT_W  RUN cycles elapsed
mis_a_data  out  DATA_W  side A value at first mismatch
mis_b_data  out  DATA_W  side B value at first mismatch

Behaviour:
- Reset (ap_rst_n=0, asynchronous, any time including mid-check):
  - state IDLE, both FIFOs empty.
  - All outputs 0: run enables, treadys, flags, counters, mis_*.
- States: IDLE, RUN, DRAIN, PASS, FAIL. Encoding is one-hot-safe; any illegal state goes to IDLE.
- IDLE:
  - start=1: next cycle RUN.
  - On entry to RUN: counters, mis_*, flags, completion latches cleared; FIFOs flushed.
- RUN:
  - a_run = ~a_done_lat; b_run = ~b_done_lat.
  - a_done_lat sets on a_complete=1 and is sticky until the next start. b_done_lat likewise.
  - a_tready = ~fifoA_full; b_tready likewise. This is registered-full based, with no same-cycle pop bypass.
  - Push on tvalid & tready.
  - Compare when both FIFOs are non-empty: pop both heads in the same cycle; beat_cnt += 1, saturating at all-ones.
  - Heads differ: mis_a_data/mis_b_data capture the heads, mismatch=1, next FAIL.
  - cycle_cnt increments every RUN cycle. When cycle_cnt == MAX_CYCLES-1 and no other exit applies: timeout=1, next FAIL.
  - Both latches set: next DRAIN. Mismatch takes priority over DRAIN, and DRAIN over timeout.
- DRAIN:
  - run enables and treadys are 0; compare/pop continues as in RUN.
  - Both FIFOs empty: PASS.
  - Exactly one FIFO empty while the other is non-empty: mismatch=1, the leftover head is captured on its side with the other side's value as 0, then FAIL.
- PASS: done=1, pass=1. FAIL: done=1, pass=0. Both hold until start, which goes to RUN with a full clear.
- start in RUN or DRAIN is ignored.
- A push and a compare-pop in the same cycle on one FIFO are legal; the count is unchanged.
- Latency: a beat accepted at cycle t is compared no earlier than t+1.

Optional Feature:
- Macro: EQ_CHK_TLAST_EN.
- Defined:
  - Adds ports a_tlast and b_tlast (in, 1 bit each).
  - FIFO entries are DATA_W+1 bits wide.
  - The comparison covers tlast as well as data; a tlast-only difference sets mismatch and goes to FAIL.
  - mis_* report data only.
- Undefined: no tlast ports; the comparison covers data only.

Decomposition:
- Package eq_chk_pkg holds:
  - state enum eq_chk_state_t;
  - localparam helpers for FIFO pointer width, $clog2(DEPTH).
- Sub-module eq_chk_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports push/pop/full/empty, with the same clock and asynchronous active-low reset;
  - instantiated twice.

Test Plan:
- Identical streams: start; both sides send 0x11,0x22,0x33, then complete at cycles 5 and 9 -> a_run falls after A completes, DRAIN, PASS; beat_cnt=3, mismatch=0.
- Data mismatch: A sends 0x11,0x22; B sends 0x11,0x23 -> FAIL after the second compare; mis_a_data=0x22, mis_b_data=0x23, beat_cnt=2.
- Count mismatch: A sends 3 beats, B sends 2, both complete -> DRAIN, then FAIL; mismatch=1, mis_a_data=third A value, mis_b_data=0.
- Backpressure: B silent; A sends 6 beats with DEPTH=4 -> a_tready low after 4 accepted; B then sends 4 matching beats -> a_tready returns high, no beat lost.
- Timeout: MAX_CYCLES=20, neither side completes -> timeout=1 and FAIL at cycle_cnt=19; pass=0.
- Reset mid-RUN: ap_rst_n low for 1 cycle after 2 beats -> all outputs 0 immediately, IDLE; start then runs a clean PASS with beat_cnt counting from 0.

Source files
------------

// File: rtl/eq_chk_pkg.sv
// eq_chk_pkg: shared state encoding and sizing helpers for the equivalence stream checker
package eq_chk_pkg;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    RUN   = 5'b00010,
    DRAIN = 5'b00100,
    PASS  = 5'b01000,
    FAIL  = 5'b10000
  } eq_chk_state_t;
  function automatic int fifo_ptr_w(int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/eq_chk_fifo.sv
// eq_chk_fifo: synchronous FIFO with flush, power-of-two depth
module eq_chk_fifo import eq_chk_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = fifo_ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/eq_stream_checker.sv
// eq_stream_checker: in-order beat comparison of two design output streams with run gating and timeout
// Defining EQ_CHK_TLAST_EN adds a_tlast/b_tlast and folds tlast into the comparison.
module eq_stream_checker import eq_chk_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic              a_tvalid,
  output logic              a_tready,
  input  logic [DATA_W-1:0] b_tdata,
  input  logic              b_tvalid,
  output logic              b_tready,
`ifdef EQ_CHK_TLAST_EN
  input  logic              a_tlast,
  input  logic              b_tlast,
`endif
  input  logic              a_complete,
  input  logic              b_complete,
  output logic              a_run,
  output logic              b_run,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic              timeout,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [DATA_W-1:0] mis_a_data,
  output logic [DATA_W-1:0] mis_b_data
);
`ifdef EQ_CHK_TLAST_EN
  localparam int FW = DATA_W + 1;
  logic [FW-1:0] a_in, b_in;
  assign a_in = {a_tlast, a_tdata};
  assign b_in = {b_tlast, b_tdata};
`else
  localparam int FW = DATA_W;
  logic [FW-1:0] a_in, b_in;
  assign a_in = a_tdata;
  assign b_in = b_tdata;
`endif
  eq_chk_state_t state, nxt;
  logic a_lat, b_lat, a_full, b_full, a_empty, b_empty;
  logic clr, cmp, diff, to_hit;
  logic [FW-1:0] a_head, b_head;
  assign clr = start & (state == IDLE || state == PASS || state == FAIL);
  assign cmp = (state == RUN || state == DRAIN) & ~a_empty & ~b_empty;
  assign diff = a_head != b_head;
  // timeout is the lowest-priority exit from RUN
  assign to_hit = (state == RUN) & ~(cmp & diff) & ~(a_lat & b_lat) & (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  eq_chk_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo_a (
    .clk(ap_clk), .rst_n(ap_rst_n), .clr(clr), .push(a_tvalid & a_tready), .pop(cmp),
    .wdata(a_in), .rdata(a_head), .full(a_full), .empty(a_empty)
  );
  eq_chk_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo_b (
    .clk(ap_clk), .rst_n(ap_rst_n), .clr(clr), .push(b_tvalid & b_tready), .pop(cmp),
    .wdata(b_in), .rdata(b_head), .full(b_full), .empty(b_empty)
  );
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE, PASS, FAIL: nxt = start ? RUN : state;
      RUN:   nxt = (cmp & diff) ? FAIL : (a_lat & b_lat) ? DRAIN : to_hit ? FAIL : RUN;
      DRAIN: nxt = (cmp & diff) ? FAIL : (a_empty & b_empty) ? PASS : (a_empty ^ b_empty) ? FAIL : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == RUN) | (state == DRAIN);
    done = (state == PASS) | (state == FAIL);
    pass = state == PASS;
    a_run = (state == RUN) & ~a_lat;
    b_run = (state == RUN) & ~b_lat;
    a_tready = (state == RUN) & ~a_full;
    b_tready = (state == RUN) & ~b_full;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n || clr) begin
      a_lat <= 1'b0;
      b_lat <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
      beat_cnt <= '0;
      cycle_cnt <= '0;
      mis_a_data <= '0;
      mis_b_data <= '0;
    end else begin
      if (state == RUN) begin
        a_lat <= a_lat | a_complete;
        b_lat <= b_lat | b_complete;
      end
      if (cmp) beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
      if (state == RUN && !to_hit) cycle_cnt <= cycle_cnt + 1'b1;
      if (to_hit) timeout <= 1'b1;
      if (cmp && diff) begin
        mismatch <= 1'b1;
        mis_a_data <= a_head[DATA_W-1:0];
        mis_b_data <= b_head[DATA_W-1:0];
      end else if (state == DRAIN && (a_empty ^ b_empty)) begin
        mismatch <= 1'b1;
        mis_a_data <= a_empty ? '0 : a_head[DATA_W-1:0];
        mis_b_data <= b_empty ? '0 : b_head[DATA_W-1:0];
      end
    end
endmodule

// File: tb/tb_eq_stream_checker.sv
// tb_eq_stream_checker: directed self-checking bench for eq_stream_checker
module tb_eq_stream_checker;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, start = 1'b0;
  logic a_tvalid = 1'b0, b_tvalid = 1'b0, a_complete = 1'b0, b_complete = 1'b0;
  logic [7:0] a_tdata = 8'h00, b_tdata = 8'h00;
  logic a_tready, b_tready, a_run, b_run, busy, done, pass, mismatch, timeout;
  logic [15:0] beat_cnt, cycle_cnt;
  logic [7:0] mis_a_data, mis_b_data;
  int checks = 0, failures = 0;
  always #5 ap_clk = ~ap_clk;
  eq_stream_checker #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .MAX_CYCLES(20)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
`ifdef EQ_CHK_TLAST_EN
    .a_tlast(1'b0), .b_tlast(1'b0),
`endif
    .a_complete(a_complete), .b_complete(b_complete),
    .a_run(a_run), .b_run(b_run), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .timeout(timeout), .beat_cnt(beat_cnt), .cycle_cnt(cycle_cnt),
    .mis_a_data(mis_a_data), .mis_b_data(mis_b_data)
  );
  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd);
    a_tvalid = av;
    a_tdata = ad;
    b_tvalid = bv;
    b_tdata = bd;
    tick;
  endtask
  task automatic kick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && !done; i++) tick;
    check(tag, 32'(done), 1);
  endtask
  initial begin
    tick;
    tick;
    check("rst_flags", 32'({busy, done, pass, mismatch, timeout, a_run, b_run, a_tready, b_tready}), 0);
    check("rst_cnt", {beat_cnt, cycle_cnt}, 0);
    check("rst_mis", 32'({mis_a_data, mis_b_data}), 0);
    ap_rst_n = 1'b1;
    tick;
    check("idle", 32'({busy, done}), 0);
    // identical streams
    kick;
    check("t1_run", 32'({busy, a_run, b_run, a_tready, b_tready}), 'b11111);
    drive(1'b1, 8'h11, 1'b1, 8'h11);
    check("t1_latency", 32'(beat_cnt), 0);
    drive(1'b1, 8'h22, 1'b1, 8'h22);
    check("t1_beat1", 32'(beat_cnt), 1);
    drive(1'b1, 8'h33, 1'b1, 8'h33);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("t1_beat3", 32'(beat_cnt), 3);
    a_complete = 1'b1;
    tick;
    a_complete = 1'b0;
    check("t1_arun", 32'({a_run, b_run}), 'b01);
    tick;
    tick;
    tick;
    b_complete = 1'b1;
    tick;
    b_complete = 1'b0;
    check("t1_cyc9", 32'(cycle_cnt), 9);
    tick;
    check("t1_drain", 32'({busy, done, a_tready, b_tready}), 'b1000);
    tick;
    check("t1_pass", 32'({done, pass, mismatch, timeout}), 'b1100);
    check("t1_cnts", {beat_cnt, cycle_cnt}, {16'd3, 16'd10});
    // data mismatch
    kick;
    check("t2_clear", 32'({done, busy, beat_cnt, cycle_cnt}), 'b01 << 32);
    drive(1'b1, 8'h11, 1'b1, 8'h11);
    drive(1'b1, 8'h22, 1'b1, 8'h23);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("t2_fail", 32'({done, pass, mismatch, busy, a_run}), 'b10100);
    check("t2_mis", 32'({mis_a_data, mis_b_data}), 'h2223);
    check("t2_beat", 32'(beat_cnt), 2);
    // beat-count mismatch found in DRAIN
    kick;
    drive(1'b1, 8'h41, 1'b1, 8'h41);
    drive(1'b1, 8'h42, 1'b1, 8'h42);
    drive(1'b1, 8'h43, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    a_complete = 1'b1;
    b_complete = 1'b1;
    tick;
    a_complete = 1'b0;
    b_complete = 1'b0;
    check("t3_run", 32'({busy, done}), 'b10);
    tick;
    check("t3_drain", 32'({busy, a_tready, a_run}), 'b100);
    tick;
    check("t3_fail", 32'({done, pass, mismatch, timeout}), 'b1010);
    check("t3_mis", 32'({mis_a_data, mis_b_data}), 'h4300);
    check("t3_beat", 32'(beat_cnt), 2);
    // backpressure
    kick;
    drive(1'b1, 8'h01, 1'b0, 8'h00);
    drive(1'b1, 8'h02, 1'b0, 8'h00);
    drive(1'b1, 8'h03, 1'b0, 8'h00);
    drive(1'b1, 8'h04, 1'b0, 8'h00);
    check("t4_full", 32'(a_tready), 0);
    drive(1'b1, 8'h05, 1'b0, 8'h00);
    check("t4_hold", 32'(a_tready), 0);
    drive(1'b1, 8'h05, 1'b1, 8'h01);
    check("t4_nopop", 32'({a_tready, beat_cnt}), 0);
    drive(1'b1, 8'h05, 1'b1, 8'h02);
    check("t4_resume", 32'({a_tready, beat_cnt}), 'h10001);
    drive(1'b1, 8'h05, 1'b1, 8'h03);
    drive(1'b1, 8'h06, 1'b1, 8'h04);
    drive(1'b0, 8'h00, 1'b1, 8'h05);
    a_complete = 1'b1;
    b_complete = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 8'h06);
    a_complete = 1'b0;
    b_complete = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("t4_drain", 32'({busy, beat_cnt}), 'h10006);
    tick;
    check("t4_pass", 32'({done, pass, mismatch}), 'b110);
    check("t4_cyc", 32'(cycle_cnt), 12);
    // timeout
    kick;
    repeat (19) tick;
    check("t5_pre", 32'({busy, timeout, cycle_cnt}), 'h20013);
    tick;
    check("t5_fail", 32'({done, pass, timeout, mismatch}), 'b1010);
    check("t5_cyc", 32'(cycle_cnt), 19);
    // start ignored in RUN, then asynchronous reset mid-RUN
    kick;
    drive(1'b1, 8'h55, 1'b1, 8'h55);
    start = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 8'h66);
    start = 1'b0;
    check("t6_nostart", {beat_cnt, cycle_cnt}, {16'd1, 16'd2});
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    ap_rst_n = 1'b0;
    #1;
    check("t6_async", 32'({busy, done, pass, mismatch, timeout, a_run, b_run, a_tready, b_tready}), 0);
    check("t6_cnt", {beat_cnt, cycle_cnt}, 0);
    tick;
    ap_rst_n = 1'b1;
    tick;
    check("t6_idle", 32'({busy, done}), 0);
    kick;
    drive(1'b1, 8'h77, 1'b1, 8'h77);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("t6_beat", 32'(beat_cnt), 1);
    a_complete = 1'b1;
    b_complete = 1'b1;
    tick;
    a_complete = 1'b0;
    b_complete = 1'b0;
    wait_done("t6_done", 10);
    check("t6_pass", 32'({pass, mismatch, beat_cnt}), 'h20001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
